lsu_sequencer: RTL and testbench

LSU_SEQUENCER -- requirements
Module: lsu_sequencer

---
 rtl/lsu_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_lsu_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: issues one memory beat for aligned requests, or a run of
// byte beats for misaligned half/word requests, then holds the response until accepted.
module lsu_sequencer #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DWIDTH-1:0] resp_rdata_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic [1:0]        mem_size_o,
    output logic              mem_unsigned_load_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i,
    output logic [15:0]       split_cnt_o
);

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              mis_q, mis_d;
    logic [1:0]        beat_q, beat_d;
    logic [DWIDTH-1:0] asm_q, asm_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic [15:0]       split_q, split_d;

    logic [DWIDTH-1:0] asm_lane;
    logic [DWIDTH-1:0] asm_ext;
    logic [7:0]        wbyte;
    logic [1:0]        last_idx;
    logic              req_mis;

    // Any size code other than byte/half is treated as a word.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        if (size == MEM_SIZE_BYTE) begin
            return 1'b0;
        end
        if (size == MEM_SIZE_HALF) begin
            return lo[0];
        end
        return lo != 2'b00;
    endfunction

    assign req_mis      = misaligned(req_size_i, req_addr_i[1:0]);
    assign resp_rdata_o = rdata_q;
    assign split_cnt_o  = split_q;

    always_comb begin
        asm_lane = asm_q;
        wbyte    = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (beat_q == 2'(k)) begin
                asm_lane[8*k +: 8] = mem_data_i[7:0];
                wbyte              = wdata_q[8*k +: 8];
            end
        end

        if (size_q == MEM_SIZE_HALF) begin
            asm_ext = uns_q ? {{(DWIDTH-16){1'b0}}, asm_lane[15:0]}
                            : {{(DWIDTH-16){asm_lane[15]}}, asm_lane[15:0]};
        end else begin
            asm_ext = asm_lane;
        end

        if (!mis_q) begin
            last_idx = 2'd0;
        end else if (size_q == MEM_SIZE_HALF) begin
            last_idx = 2'd1;
        end else begin
            last_idx = 2'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        mis_d   = mis_q;
        beat_d  = beat_q;
        asm_d   = asm_q;
        rdata_d = rdata_q;
        split_d = split_q;

        req_ready_o         = 1'b0;
        resp_valid_o        = 1'b0;
        mem_addr_o          = '0;
        mem_data_o          = '0;
        mem_size_o          = '0;
        mem_unsigned_load_o = 1'b0;
        mem_read_en_o       = 1'b0;
        mem_write_en_o      = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    mis_d   = req_mis;
                    beat_d  = '0;
                    asm_d   = '0;
                    state_d = ACCESS;
                    if (req_mis && split_q != '1) begin
                        split_d = split_q + 16'd1;
                    end
                end
            end

            ACCESS: begin
                mem_addr_o          = addr_q + AWIDTH'(beat_q);
                mem_size_o          = mis_q ? MEM_SIZE_BYTE : size_q;
                mem_unsigned_load_o = mis_q | uns_q;
                mem_read_en_o       = !we_q;
                mem_write_en_o      = we_q;
                if (we_q) begin
                    mem_data_o = mis_q ? {{(DWIDTH-8){1'b0}}, wbyte} : wdata_q;
                end else if (mis_q) begin
                    asm_d = asm_lane;
                end

                if (beat_q == last_idx) begin
                    state_d = RESP;
                    if (we_q) begin
                        rdata_d = '0;
                    end else begin
                        rdata_d = mis_q ? asm_ext : mem_data_i;
                    end
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end

            RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Enables must drop in the same cycle reset is asserted, not one edge later.
        if (!rst) begin
            mem_read_en_o  = 1'b0;
            mem_write_en_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            mis_q   <= 1'b0;
            beat_q  <= '0;
            asm_q   <= '0;
            rdata_q <= '0;
            split_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            mis_q   <= mis_d;
            beat_q  <= beat_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
            split_q <= split_d;
        end
    end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Bench for lsu_sequencer: byte-array memory model plus a byte-level reference
// of what each request must read or write, with directed and random requests.
module tb_lsu_sequencer;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [31:0] B   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [1:0]  req_size_i;
    logic        resp_valid_o, resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
    logic [1:0]  mem_size_o;
    logic        mem_unsigned_load_o, mem_read_en_o, mem_write_en_o;
    logic [15:0] split_cnt_o;

    logic [7:0]  mem     [1024];
    logic [7:0]  ref_mem [1024];
    logic [9:0]  rd_a;
    logic [7:0]  rb0, rb1, rb2, rb3;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [15:0] exp_split = '0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    lsu_sequencer #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid_i         (req_valid_i),
        .req_ready_o         (req_ready_o),
        .req_we_i            (req_we_i),
        .req_addr_i          (req_addr_i),
        .req_wdata_i         (req_wdata_i),
        .req_size_i          (req_size_i),
        .req_unsigned_i      (req_unsigned_i),
        .resp_valid_o        (resp_valid_o),
        .resp_ready_i        (resp_ready_i),
        .resp_rdata_o        (resp_rdata_o),
        .mem_addr_o          (mem_addr_o),
        .mem_data_o          (mem_data_o),
        .mem_size_o          (mem_size_o),
        .mem_unsigned_load_o (mem_unsigned_load_o),
        .mem_read_en_o       (mem_read_en_o),
        .mem_write_en_o      (mem_write_en_o),
        .mem_data_i          (mem_data_i),
        .split_cnt_o         (split_cnt_o)
    );

    // Combinational memory read port (1 KiB window, addresses alias modulo 1024).
    always_comb begin
        rd_a = mem_addr_o[9:0];
        rb0  = mem[rd_a];
        rb1  = mem[rd_a + 10'd1];
        rb2  = mem[rd_a + 10'd2];
        rb3  = mem[rd_a + 10'd3];
        case (mem_size_o)
            SZ_B:    mem_data_i = {{24{rb0[7] & ~mem_unsigned_load_o}}, rb0};
            SZ_H:    mem_data_i = {{16{rb1[7] & ~mem_unsigned_load_o}}, rb1, rb0};
            default: mem_data_i = {rb3, rb2, rb1, rb0};
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int unsigned nbytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 1;
            SZ_H:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int unsigned n, input logic uns);
        logic [31:0] v;
        v = '0;
        for (int unsigned i = 0; i < n; i++) begin
            v = v | (32'(ref_mem[10'(a + i)]) << (8 * i));
        end
        if (n < 4 && !uns && v[8*n-1]) begin
            v = v | (32'hFFFF_FFFF << (8 * n));
        end
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            ref_mem[10'(a + i)] = 8'(wd >> (8 * i));
        end
    endtask

    // Applies the beat currently on the write port to the memory model.
    task automatic mem_write();
        int unsigned n;
        n = nbytes(mem_size_o);
        for (int unsigned i = 0; i < n; i++) begin
            mem[10'(mem_addr_o + i)] = 8'(mem_data_o >> (8 * i));
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        mem[10'(a)]     = b;
        ref_mem[10'(a)] = b;
    endtask

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input logic uns, input int unsigned hold,
                          output logic [31:0] rdata);
        int unsigned nb, n_exp, beats, cyc;
        logic        mis;
        logic [31:0] exp_rd;
        nb    = nbytes(sz);
        mis   = (a % nb) != 0;
        n_exp = mis ? nb : 1;
        if (we) begin
            ref_store(a, wd, nb);
            exp_rd = '0;
        end else begin
            exp_rd = ref_load(a, nb, uns);
        end
        if (mis && exp_split != 16'hFFFF) exp_split++;

        check("req_ready_idle", 32'(req_ready_o), 32'd1);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_addr_i     = a;
        req_wdata_i    = wd;
        req_size_i     = sz;
        req_unsigned_i = uns;
        @(posedge clk); #1;
        req_valid_i = 1'b0;

        beats = 0;
        cyc   = 0;
        while (!resp_valid_o && cyc < 16) begin
            if (mem_read_en_o || mem_write_en_o) begin
                check("beat_we", 32'(mem_write_en_o), 32'(we));
                check("beat_re", 32'(mem_read_en_o), 32'(!we));
                check("beat_addr", mem_addr_o, a + beats);
                check("beat_size", 32'(mem_size_o), 32'(mis ? SZ_B : sz));
                check("beat_uns", 32'(mem_unsigned_load_o), 32'(mis | uns));
                if (we) begin
                    check("beat_wdata", mem_data_o, mis ? ((wd >> (8 * beats)) & 32'hFF) : wd);
                    mem_write();
                end
                beats++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("beat_count", beats, n_exp);
        check("latency", cyc, n_exp);
        check("resp_valid", 32'(resp_valid_o), 32'd1);
        rdata = resp_rdata_o;
        check("rdata", rdata, exp_rd);

        // A pending request during the response must not be taken, even in the handshake cycle.
        req_valid_i = 1'b1;
        for (int unsigned h = 0; h < hold; h++) begin
            check("hold_valid", 32'(resp_valid_o), 32'd1);
            check("hold_rdata", resp_rdata_o, exp_rd);
            check("hold_ready", 32'(req_ready_o), 32'd0);
            check("hold_en", 32'({mem_read_en_o, mem_write_en_o}), 32'd0);
            @(posedge clk); #1;
        end
        resp_ready_i = 1'b1;
        @(posedge clk); #1;
        resp_ready_i = 1'b0;
        req_valid_i  = 1'b0;
        check("post_ready", 32'(req_ready_o), 32'd1);
        check("post_valid", 32'(resp_valid_o), 32'd0);
        check("post_en", 32'({mem_read_en_o, mem_write_en_o}), 32'd0);
        check("split_cnt", 32'(split_cnt_o), 32'(exp_split));
        if (we) begin
            for (int unsigned i = 0; i < nb; i++) begin
                check("mem_byte", 32'(mem[10'(a + i)]), 32'(ref_mem[10'(a + i)]));
            end
        end
    endtask

    initial begin
        logic [31:0] a, wd;
        logic [1:0]  sz;

        for (int unsigned i = 0; i < 1024; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        rst            = 1'b0;
        req_valid_i    = 1'b0;
        req_we_i       = 1'b0;
        req_addr_i     = '0;
        req_wdata_i    = '0;
        req_size_i     = '0;
        req_unsigned_i = 1'b0;
        resp_ready_i   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        check("rst_rdata", resp_rdata_o, 32'd0);
        check("rst_split", 32'(split_cnt_o), 32'd0);
        check("rst_en", 32'({mem_read_en_o, mem_write_en_o}), 32'd0);
        rst = 1'b1;
        check("rel_ready", 32'(req_ready_o), 32'd1);

        // Aligned word load.
        preload(B + 32'h10, 8'h21);
        preload(B + 32'h11, 8'h43);
        preload(B + 32'h12, 8'h65);
        preload(B + 32'h13, 8'h87);
        do_req(1'b0, B + 32'h10, 32'h0, SZ_W, 1'b0, 0, rd);
        check("t_aligned_word", rd, 32'h8765_4321);

        // Misaligned signed half load.
        preload(B + 32'h11, 8'h80);
        preload(B + 32'h12, 8'hFF);
        do_req(1'b0, B + 32'h11, 32'h0, SZ_H, 1'b0, 0, rd);
        check("t_mis_half", rd, 32'hFFFF_FF80);
        check("t_mis_half_split", 32'(split_cnt_o), 32'd1);

        // Misaligned word store with a stalled response, then reload.
        do_req(1'b1, B + 32'h3, 32'hAABB_CCDD, SZ_W, 1'b0, 5, rd);
        do_req(1'b0, B + 32'h3, 32'h0, SZ_W, 1'b0, 0, rd);
        check("t_store_reload", rd, 32'hAABB_CCDD);

        // Unsigned half load wrapping past the top of the address space.
        do_req(1'b0, 32'hFFFF_FFFF, 32'h0, SZ_H, 1'b1, 0, rd);
        check("t_wrap_upper", rd >> 16, 32'h0);

        // Reset during beat 2 of a misaligned word store.
        a  = B + 32'h21;
        wd = 32'h1122_3344;
        check("r_ready", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = a;
        req_wdata_i = wd;
        req_size_i  = SZ_W;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        check("r_beat1_we", 32'(mem_write_en_o), 32'd1);
        check("r_beat1_addr", mem_addr_o, a);
        if (mem_write_en_o) mem_write();
        ref_mem[10'(a)] = 8'h44;
        @(posedge clk); #1;
        check("r_beat2_addr", mem_addr_o, a + 32'd1);
        rst = 1'b0;
        #1;
        check("r_we_forced", 32'(mem_write_en_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_split = '0;
        check("r_ready_after", 32'(req_ready_o), 32'd1);
        check("r_split", 32'(split_cnt_o), 32'd0);
        for (int unsigned c = 0; c < 3; c++) begin
            check("r_no_resp", 32'(resp_valid_o), 32'd0);
            check("r_no_en", 32'({mem_read_en_o, mem_write_en_o}), 32'd0);
            @(posedge clk); #1;
        end
        for (int unsigned i = 0; i < 4; i++) begin
            check("r_mem", 32'(mem[10'(a + i)]), 32'(ref_mem[10'(a + i)]));
        end

        // Random traffic.
        for (int unsigned t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            end else begin
                a = 32'($urandom_range(0, 255));
            end
            sz = 2'($urandom_range(0, 3));
            wd = $urandom;
            do_req(1'($urandom_range(0, 1)), a, wd, sz, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
